key_entry_ctrl: RTL and testbench

Parametrised successor to the two-key decimal input unit. It takes NDIGITS raw push-buttons, one per decimal digit, and debounces each. Every press increments that digit modulo 10. On an enter key, the BCD entry is converted to binary with a sequential multiply-add, and the result is offered to the SoPC over a valid/ack handshake. It sits between the board keys and the CPU data input, clocked by the undivided 10 kHz board clock.

---
 rtl/key_entry_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl
// Multi-digit decimal key entry unit. NDIGITS raw push-buttons each step one
// BCD digit modulo 10. A clear key zeroes the entry. An enter key converts the
// BCD entry to binary with one multiply-add per digit, MSD first. The result is
// offered on a valid/ack handshake.
// All raw keys pass through a 2-FF synchroniser and a stability-counter
// debouncer. A press event is a registered one-cycle pulse on the debounced
// rising edge.
// Optional feature: define KEY_ENTRY_AUTOREPEAT_EN to make held digit keys
// auto-repeat every REPEAT_CYC cycles. Clear and enter never repeat.
module key_entry_ctrl #(
  parameter int NDIGITS      = 2,
  parameter int DATA_W       = 32,
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_CYC   = 5000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NDIGITS-1:0]     key_i,
  input  logic                   clear_i,
  input  logic                   enter_i,
  input  logic                   ack_i,
  output logic [4*NDIGITS-1:0]   digits_o,
  output logic [DATA_W-1:0]      data_o,
  output logic                   valid_o,
  output logic                   busy_o
);

  // Input vector layout: digit keys in the low bits, then clear, then enter.
  localparam int NIN   = NDIGITS + 2;
  localparam int CLR   = NDIGITS;
  localparam int ENT   = NDIGITS + 1;
  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam int IDX_W = $clog2(NDIGITS + 2);

  typedef enum logic [1:0] {
    EDIT    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;

  logic [NIN-1:0]       raw;
  logic [NIN-1:0]       sync_p0;
  logic [NIN-1:0]       sync_p1;
  logic [NIN-1:0]       level;
  logic [NIN-1:0]       level_d;
  logic [NIN-1:0]       rise;
  logic [CNT_W-1:0]     db_cnt [NIN];

  logic [NDIGITS-1:0]   key_ev;
  logic                 clear_ev;
  logic                 enter_ev;

  logic [4*NDIGITS-1:0] shadow;
  logic [DATA_W-1:0]    acc;

  assign raw  = {enter_i, clear_i, key_i};
  assign rise = level & ~level_d;

  // Increment one BCD digit, wrapping 9 back to 0.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Apply this cycle's press events to the entry; clear overrides digit presses.
  function automatic logic [4*NDIGITS-1:0] edit_digits(
    input logic [4*NDIGITS-1:0] cur,
    input logic [NDIGITS-1:0]   inc,
    input logic                 clr
  );
    logic [4*NDIGITS-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = '0;
    end else begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (inc[i]) nxt[4*i +: 4] = bcd_inc(cur[4*i +: 4]);
      end
    end
    return nxt;
  endfunction

  // Select the digit consumed at conversion step pos (step 0 = MSD).
  function automatic logic [3:0] pick_digit(
    input logic [4*NDIGITS-1:0] sh,
    input logic [IDX_W-1:0]     pos
  );
    int sel;
    sel = NDIGITS - 1 - int'(pos);
    if (sel < 0) sel = 0;
    return sh[4*sel +: 4];
  endfunction

  // One conversion step: acc*10 + digit. DATA_W is sized so this never overflows.
  function automatic logic [DATA_W-1:0] mac10(
    input logic [DATA_W-1:0] a,
    input logic [3:0]        d
  );
    return a * DATA_W'(10) + DATA_W'(d);
  endfunction

  // Two-flop synchroniser for every raw key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the level follows the synchronised input after DEBOUNCE_CYC differing cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      level_d <= level;
      for (int i = 0; i < NIN; i++) begin
        if (sync_p1[i] != level[i]) begin
          if (db_cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
            level[i]  <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered press pulses for clear and enter: one per debounced press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_ev <= 1'b0;
      enter_ev <= 1'b0;
    end else begin
      clear_ev <= rise[CLR];
      enter_ev <= rise[ENT];
    end
  end

`ifdef KEY_ENTRY_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_CYC < 2) ? 1 : $clog2(REPEAT_CYC + 1);

  logic [RPT_W-1:0] rpt_cnt [NDIGITS];

  // Digit press pulses: initial edge, then one every REPEAT_CYC cycles while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_ev <= '0;
      for (int i = 0; i < NDIGITS; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (!level[i]) begin
          key_ev[i]  <= 1'b0;
          rpt_cnt[i] <= '0;
        end else if (rise[i] || (rpt_cnt[i] == RPT_W'(REPEAT_CYC - 1))) begin
          key_ev[i]  <= 1'b1;
          rpt_cnt[i] <= '0;
        end else begin
          key_ev[i]  <= 1'b0;
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Digit press pulses: exactly one per debounced press. REPEAT_CYC has no
  // role in this build and reduces to an all-ones mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_ev <= '0;
    end else begin
      key_ev <= rise[NDIGITS-1:0] & {NDIGITS{REPEAT_CYC >= 0}};
    end
  end
`endif

  // Entry FSM: edit digits, run the MSD-first conversion, hold result until acked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EDIT;
      idx      <= '0;
      digits_o <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        EDIT: begin
          digits_o <= edit_digits(digits_o, key_ev, clear_ev);
          if (enter_ev) begin
            state  <= CONVERT;
            idx    <= '0;
            busy_o <= 1'b1;
          end
        end
        CONVERT: begin
          // Steps 0..NDIGITS-1 accumulate; the extra step publishes the result.
          if (idx < IDX_W'(NDIGITS)) begin
            idx <= idx + 1'b1;
            if (idx == IDX_W'(NDIGITS - 1)) busy_o <= 1'b0;
          end else begin
            data_o  <= acc;
            valid_o <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          digits_o <= edit_digits(digits_o, key_ev, clear_ev);
          if (valid_o && ack_i) begin
            valid_o <= 1'b0;
            state   <= EDIT;
          end
        end
        default: begin
          state   <= EDIT;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Conversion datapath: snapshot the entry on enter, then multiply-add per digit.
  always_ff @(posedge clk) begin
    if ((state == EDIT) && enter_ev) begin
      shadow <= digits_o;
      acc    <= '0;
    end else if ((state == CONVERT) && (idx < IDX_W'(NDIGITS))) begin
      acc <= mac10(acc, pick_digit(shadow, idx));
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Testbench for key_entry_ctrl (NDIGITS=2, DATA_W=32, DEBOUNCE_CYC=4, REPEAT_CYC=8).
// A behavioural model keeps the decimal digits as integers and derives the
// committed value and auto-repeat counts arithmetically.
module tb_key_entry_ctrl;

  localparam int ND  = 2;
  localparam int DW  = 32;
  localparam int DEB = 4;
  localparam int REP = 8;

  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic [ND-1:0]   key   = '0;
  logic            clear = 1'b0;
  logic            enter = 1'b0;
  logic            ack   = 1'b0;
  logic [4*ND-1:0] digits;
  logic [DW-1:0]   data;
  logic            valid;
  logic            busy;

  int errors = 0;
  int checks = 0;

  int md [ND];
  int mdata = 0;

  bit hold_watch = 1'b0;
  int hold_bad   = 0;

  always #5 clk = ~clk;

  key_entry_ctrl #(
    .NDIGITS(ND), .DATA_W(DW), .DEBOUNCE_CYC(DEB), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst(rst), .key_i(key), .clear_i(clear), .enter_i(enter),
    .ack_i(ack), .digits_o(digits), .data_o(data), .valid_o(valid), .busy_o(busy)
  );

  // While the held result is being watched, it must stay valid and unchanged.
  always @(negedge clk) begin
    if (hold_watch && ((data !== DW'(mdata)) || (valid !== 1'b1))) hold_bad++;
  end

  function automatic logic [4*ND-1:0] model_bcd();
    logic [4*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(md[i]);
    return r;
  endfunction

  function automatic int model_value();
    int v;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * 10 + md[i];
    return v;
  endfunction

  // Number of press events for a digit key whose raw level is held for h cycles.
  function automatic int events_for_hold(input int h);
`ifdef KEY_ENTRY_AUTOREPEAT_EN
    return (h - 1) / REP + 1;
`else
    return (h > 0) ? 1 : 0;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // k < ND: digit key k; k == ND: clear key.
  task automatic press(input int k, input int hold, input int gap);
    if (k < ND) key[k] = 1'b1; else clear = 1'b1;
    cyc(hold);
    key = '0;
    clear = 1'b0;
    cyc(gap);
    if (k < ND) md[k] = (md[k] + events_for_hold(hold)) % 10;
    else for (int i = 0; i < ND; i++) md[i] = 0;
  endtask

  task automatic press_both(input int hold, input int gap);
    key = '1;
    cyc(hold);
    key = '0;
    cyc(gap);
    for (int i = 0; i < ND; i++) md[i] = (md[i] + events_for_hold(hold)) % 10;
  endtask

  // Press enter and wait (bounded) for valid; found=0 on timeout.
  task automatic do_enter(output bit found);
    found = 1'b0;
    enter = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == DEB + 2) enter = 1'b0;
      if (valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    enter = 1'b0;
  endtask

  task automatic test_reset();
    cyc(2);
    checks++; if (digits !== '0) begin errors++; $display("FAIL reset_digits: got %0h expected 0", digits); end
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b1;
    cyc(3);
  endtask

  // Key high from edge 0: digit must change at edge DEB+3, not before.
  task automatic test_latency();
    key[0] = 1'b1;
    cyc(DEB + 3);
    checks++; if (digits !== model_bcd()) begin errors++; $display("FAIL latency_early: got %0h expected %0h", digits, model_bcd()); end
    cyc(1);
    md[0] = 1;
    checks++; if (digits !== model_bcd()) begin errors++; $display("FAIL latency_update: got %0h expected %0h", digits, model_bcd()); end
    cyc(1);
    key = '0;
    cyc(10);
  endtask

  task automatic test_glitch();
    key[0] = 1'b1; cyc(3);
    key[0] = 1'b0; cyc(2);
    key[0] = 1'b1; cyc(3);
    key[0] = 1'b0; cyc(15);
    checks++; if (digits !== model_bcd()) begin errors++; $display("FAIL glitch: got %0h expected %0h", digits, model_bcd()); end
  endtask

  task automatic test_wrap();
    press(ND, 6, 8);
    checks++; if (digits !== 8'h00) begin errors++; $display("FAIL clear: got %0h expected 00", digits); end
    for (int n = 1; n <= 10; n++) begin
      press(0, 6, 8);
      if (n == 9) begin
        checks++; if (digits[3:0] !== 4'd9) begin errors++; $display("FAIL wrap_nine: got %0h expected 9", digits[3:0]); end
      end
    end
    checks++; if (digits !== model_bcd() || digits[3:0] !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0h expected %0h", digits, model_bcd()); end
  endtask

  task automatic test_enter37();
    int busy_cnt, first_busy, last_busy, first_valid;
    for (int n = 0; n < 3; n++) press(1, 6, 8);
    for (int n = 0; n < 7; n++) press(0, 6, 8);
    checks++; if (digits !== 8'h37) begin errors++; $display("FAIL entry37: got %0h expected 37", digits); end
    busy_cnt = 0; first_busy = -1; last_busy = -1; first_valid = -1;
    enter = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == DEB + 2) enter = 1'b0;
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = k;
        last_busy = k;
      end
      if (valid === 1'b1) begin
        first_valid = k;
        break;
      end
    end
    enter = 1'b0;
    checks++; if (first_valid < 0) begin errors++; $display("FAIL enter_timeout: got no valid expected valid within 60 cycles"); end
    checks++; if (first_busy != DEB + 4) begin errors++; $display("FAIL busy_start: got %0d expected %0d", first_busy, DEB + 4); end
    checks++; if (busy_cnt != ND) begin errors++; $display("FAIL busy_len: got %0d expected %0d", busy_cnt, ND); end
    checks++; if (first_valid != DEB + 5 + ND) begin errors++; $display("FAIL valid_time: got %0d expected %0d", first_valid, DEB + 5 + ND); end
    mdata = model_value();
    checks++; if (data !== DW'(37) || data !== DW'(mdata)) begin errors++; $display("FAIL data37: got %0d expected 37", data); end
  endtask

  task automatic test_hold();
    bit found;
    int vcnt;
    hold_bad = 0;
    hold_watch = 1'b1;
    for (int n = 0; n < 7; n++) press(1, 6, 8);
    for (int n = 0; n < 8; n++) press(0, 6, 8);
    enter = 1'b1; cyc(6); enter = 1'b0; cyc(20);
    hold_watch = 1'b0;
    checks++; if (digits !== 8'h05 || digits !== model_bcd()) begin errors++; $display("FAIL hold_edit: got %0h expected 05", digits); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL hold_frozen: got %0d bad cycles expected 0", hold_bad); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ack_clears: got %0b expected 0", valid); end
    cyc(3);
    // Back in EDIT: a new enter converts 05; with ack already high valid lasts 1 cycle.
    ack = 1'b1;
    do_enter(found);
    checks++; if (!found || data !== DW'(model_value())) begin errors++; $display("FAIL reenter: got %0d (found=%0b) expected %0d", data, found, model_value()); end
    vcnt = found ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid === 1'b1) vcnt++;
    end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL min_valid: got %0d cycles expected 1", vcnt); end
    ack = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset_convert();
    bit vseen;
    bit got_busy;
    got_busy = 1'b0;
    enter = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == DEB + 2) enter = 1'b0;
      if (busy === 1'b1) begin
        got_busy = 1'b1;
        break;
      end
    end
    enter = 1'b0;
    checks++; if (!got_busy) begin errors++; $display("FAIL convert_start: got no busy expected busy"); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) md[i] = 0;
    mdata = 0;
    checks++; if (digits !== '0 || data !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_reset: got d=%0h data=%0h v=%0b b=%0b expected all 0", digits, data, valid, busy);
    end
    cyc(2);
    rst = 1'b1;
    vseen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) vseen = 1'b1;
    end
    checks++; if (vseen) begin errors++; $display("FAIL abort_no_valid: got activity expected none"); end
    press(1, 6, 8);
    checks++; if (digits !== model_bcd()) begin errors++; $display("FAIL pre_clear: got %0h expected %0h", digits, model_bcd()); end
    key[0] = 1'b1; clear = 1'b1;
    cyc(6);
    key = '0; clear = 1'b0;
    cyc(8);
    for (int i = 0; i < ND; i++) md[i] = 0;
    checks++; if (digits !== 8'h00) begin errors++; $display("FAIL clear_wins: got %0h expected 00", digits); end
  endtask

  task automatic test_repeat();
    logic [3:0] want;
`ifdef KEY_ENTRY_AUTOREPEAT_EN
    want = 4'd4;
`else
    want = 4'd1;
`endif
    press(0, 30, 15);
    checks++; if (digits[3:0] !== want || digits !== model_bcd()) begin errors++; $display("FAIL repeat: got %0h expected digit0=%0d", digits, want); end
  endtask

  task automatic test_random();
    bit found;
    int np, kind, hold, gap;
    for (int r = 0; r < 6; r++) begin
      np = $urandom_range(3, 7);
      for (int n = 0; n < np; n++) begin
        kind = $urandom_range(0, 9);
        hold = $urandom_range(DEB, 8);
        gap  = $urandom_range(DEB + 2, 12);
        if (kind == 0) press(ND, hold, gap);
        else if (kind == 1) press_both(hold, gap);
        else press(kind % ND, hold, gap);
        checks++; if (digits !== model_bcd()) begin errors++; $display("FAIL rand_digits: got %0h expected %0h", digits, model_bcd()); end
      end
      do_enter(found);
      checks++; if (!found || data !== DW'(model_value())) begin errors++; $display("FAIL rand_data: got %0d (found=%0b) expected %0d", data, found, model_value()); end
      cyc($urandom_range(0, 5));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rand_ack: got %0b expected 0", valid); end
      cyc(3);
    end
  endtask

  initial begin
    for (int i = 0; i < ND; i++) md[i] = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_wrap();
    test_enter37();
    test_hold();
    test_reset_convert();
    test_repeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
